// File: rtl/i2c_target_responder.sv
// I2C target: oversamples SCL/SDA on CLK, decodes START/STOP, matches a 7-bit
// address, receives NUM_BYTES-byte writes into RX_DATA and serves reads from TX_DATA.
`timescale 1ns/1ps
module i2c_target_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_BYTES   = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   SCL,
  input  logic                   SDA_IN,
  input  logic [6:0]             I2C_ADDR,
  input  logic [8*NUM_BYTES-1:0] TX_DATA,
  output logic                   SDA_OUT,
  output logic                   SDA_OE,
  output logic [8*NUM_BYTES-1:0] RX_DATA,
  output logic                   RX_VALID,
  output logic                   BUSY
);

  localparam int unsigned DW       = 8 * NUM_BYTES;
  localparam logic [7:0]  LAST_IDX = 8'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_WR_BYTE  = 3'd3,
    S_WR_ACK   = 3'd4,
    S_RD_BYTE  = 3'd5,
    S_RD_ACK   = 3'd6,
    S_IGNORE   = 3'd7
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;

  state_t                 r_state;
  logic [3:0]             r_bit_cnt;
  logic [7:0]             r_byte_idx;
  logic [7:0]             r_shift;
  logic                   r_rw;
  logic [DW-1:0]          r_rx_acc;
  logic [DW-1:0]          r_tx_sh;
  logic                   r_oe;
  logic                   r_out;
  logic [DW-1:0]          r_rx_data;
  logic                   r_rx_valid;

  logic                   w_scl;
  logic                   w_sda;
  logic                   w_scl_rise;
  logic                   w_scl_fall;
  logic                   w_start;
  logic                   w_stop;
  logic [DW-1:0]          w_rx_next;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], SCL};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], SDA_IN};
      r_scl_prev <= r_scl_sync[SYNC_STAGES-1];
      r_sda_prev <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

  generate
    if (NUM_BYTES > 1) begin : g_acc_multi
      assign w_rx_next = {r_rx_acc[DW-9:0], r_shift};
    end else begin : g_acc_single
      assign w_rx_next = r_shift;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_rw       <= 1'b0;
      r_rx_acc   <= '0;
      r_tx_sh    <= '0;
      r_oe       <= 1'b0;
      r_out      <= 1'b1;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_stop) begin
        r_state <= S_IDLE;
        r_oe    <= 1'b0;
        r_out   <= 1'b1;
      end else if (w_start) begin
        r_state    <= S_ADDR;
        r_bit_cnt  <= '0;
        r_byte_idx <= '0;
        r_rx_acc   <= '0;
        r_oe       <= 1'b0;
        r_out      <= 1'b1;
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              if (r_shift[7:1] == I2C_ADDR) begin
                r_state <= S_ADDR_ACK;
                r_rw    <= r_shift[0];
                r_oe    <= 1'b1;
                r_out   <= 1'b0;
              end else begin
                r_state <= S_IGNORE;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt  <= '0;
              r_byte_idx <= '0;
              if (!r_rw) begin
                r_state <= S_WR_BYTE;
                r_oe    <= 1'b0;
                r_out   <= 1'b1;
              end else begin
                // MSB goes straight to the pin; the register keeps the remaining bits left-aligned
                r_state <= S_RD_BYTE;
                r_tx_sh <= {TX_DATA[DW-2:0], 1'b0};
                r_out   <= TX_DATA[DW-1];
              end
            end
          end
          S_WR_BYTE: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_state  <= S_WR_ACK;
              r_rx_acc <= w_rx_next;
              r_oe     <= 1'b1;
              r_out    <= 1'b0;
            end
          end
          S_WR_ACK: begin
            if (w_scl_fall) begin
              r_oe      <= 1'b0;
              r_out     <= 1'b1;
              r_bit_cnt <= '0;
              if (r_byte_idx < LAST_IDX) begin
                r_byte_idx <= r_byte_idx + 8'd1;
                r_state    <= S_WR_BYTE;
              end else begin
                r_rx_data  <= r_rx_acc;
                r_rx_valid <= 1'b1;
                r_state    <= S_IGNORE;
              end
            end
          end
          S_RD_BYTE: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 4'd7) begin
                r_state <= S_RD_ACK;
                r_oe    <= 1'b0;
                r_out   <= 1'b1;
              end else begin
                r_out     <= r_tx_sh[DW-1];
                r_tx_sh   <= {r_tx_sh[DW-2:0], 1'b0};
                r_oe      <= 1'b1;
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (w_scl_rise) begin
              if (!w_sda && r_byte_idx < LAST_IDX) begin
                // count wraps to 0 on the fall that drives the next byte's MSB
                r_byte_idx <= r_byte_idx + 8'd1;
                r_bit_cnt  <= 4'hF;
                r_state    <= S_RD_BYTE;
              end else begin
                r_state <= S_IGNORE;
              end
            end
          end
          default: begin
            r_oe  <= 1'b0;
            r_out <= 1'b1;
          end
        endcase
      end
    end
  end

  // Reset gates the pin drive combinationally so the bus is freed without waiting for CLK.
  assign SDA_OE   = r_oe & RESET;
  assign SDA_OUT  = r_out | ~RESET;
  assign RX_DATA  = r_rx_data;
  assign RX_VALID = r_rx_valid;
  assign BUSY     = (r_state != S_IDLE) && (r_state != S_IGNORE);

endmodule
